// File: rtl/collision_detector_pkg.sv
// collision_detector_pkg: shared game state encoding, coordinate width and "no obstacle pixel" encoding
package collision_detector_pkg;
  localparam int COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;
  localparam coord_t NONE_X = '0;
  localparam coord_t NONE_Y = '0;
  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    INVULN,
    GAME_OVER
  } state_t;
  function automatic logic is_pixel(input coord_t x, input coord_t y);
    return x != NONE_X || y != NONE_Y;
  endfunction
endpackage

// File: rtl/collision_detector_if.sv
// collision_detector_if: master drives vsync_in/game_on/menu_on/obstacle_x,y/mouse_xpos,ypos; slave returns hit/lives/invuln/game_over
interface collision_detector_if;
  import collision_detector_pkg::*;
  logic       vsync_in;
  logic       game_on;
  logic       menu_on;
  coord_t     obstacle_x;
  coord_t     obstacle_y;
  coord_t     mouse_xpos;
  coord_t     mouse_ypos;
  logic       hit;
  logic [3:0] lives;
  logic       invuln;
  logic       game_over;
  modport master (
    output vsync_in, game_on, menu_on, obstacle_x, obstacle_y, mouse_xpos, mouse_ypos,
    input  hit, lives, invuln, game_over
  );
  modport slave (
    input  vsync_in, game_on, menu_on, obstacle_x, obstacle_y, mouse_xpos, mouse_ypos,
    output hit, lives, invuln, game_over
  );
endinterface

// File: rtl/collision_detector_box_hit_test.sv
// collision_detector_box_hit_test: two-stage registered test of pixel px/py/valid against cursor box at mx/my, result in_box
module collision_detector_box_hit_test
  import collision_detector_pkg::*;
#(
  parameter int CURSOR_W = 16,
  parameter int CURSOR_H = 16
) (
  input  logic   pclk,
  input  logic   rst_n,
  input  coord_t px,
  input  coord_t py,
  input  logic   valid,
  input  coord_t mx,
  input  coord_t my,
  output logic   in_box
);
  localparam logic [COORD_W:0] BOX_W = (COORD_W+1)'(CURSOR_W);
  localparam logic [COORD_W:0] BOX_H = (COORD_W+1)'(CURSOR_H);
  coord_t x_q;
  coord_t y_q;
  logic   v_q;
  logic [COORD_W:0] xe;
  logic [COORD_W:0] ye;
  logic [COORD_W:0] mxe;
  logic [COORD_W:0] mye;
  logic   hit_c;
  assign xe  = {1'b0, x_q};
  assign ye  = {1'b0, y_q};
  assign mxe = {1'b0, mx};
  assign mye = {1'b0, my};
  assign hit_c = v_q && xe >= mxe && xe < mxe + BOX_W && ye >= mye && ye < mye + BOX_H;
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      v_q    <= 1'b0;
      in_box <= 1'b0;
    end else begin
      x_q    <= px;
      y_q    <= py;
      v_q    <= valid;
      in_box <= hit_c;
    end
  end
endmodule

// File: rtl/collision_detector.sv
// collision_detector: per-frame cursor/obstacle collision, lives, invulnerability and game-over; ports pclk, rst_n, bus (slave)
module collision_detector
  import collision_detector_pkg::*;
#(
  parameter int CURSOR_W      = 16,
  parameter int CURSOR_H      = 16,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60
) (
  input logic                 pclk,
  input logic                 rst_n,
  collision_detector_if.slave bus
);
  localparam int CNT_W = INVULN_FRAMES > 1 ? $clog2(INVULN_FRAMES) : 1;
  state_t     state;
  state_t     state_n;
  logic       vsync_q;
  logic       vsync_q2;
  logic       frame_edge;
  coord_t     mx;
  coord_t     my;
  logic       in_box;
  logic       frame_hit;
  logic       frame_hit_n;
  logic [3:0] lives_q;
  logic [3:0] lives_n;
  logic       hit_q;
  logic       hit_n;
  logic       invuln_q;
  logic       invuln_n;
  logic       go_q;
  logic       go_n;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;
  logic       stop;
  assign frame_edge = vsync_q & ~vsync_q2;
  assign stop       = bus.menu_on | ~bus.game_on;
  collision_detector_box_hit_test #(
    .CURSOR_W(CURSOR_W),
    .CURSOR_H(CURSOR_H)
  ) u_box (
    .pclk  (pclk),
    .rst_n (rst_n),
    .px    (bus.obstacle_x),
    .py    (bus.obstacle_y),
    .valid (is_pixel(bus.obstacle_x, bus.obstacle_y)),
    .mx    (mx),
    .my    (my),
    .in_box(in_box)
  );
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state     <= IDLE;
      vsync_q   <= 1'b0;
      vsync_q2  <= 1'b0;
      mx        <= '0;
      my        <= '0;
      frame_hit <= 1'b0;
      lives_q   <= '0;
      hit_q     <= 1'b0;
      invuln_q  <= 1'b0;
      go_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state     <= state_n;
      vsync_q   <= bus.vsync_in;
      vsync_q2  <= vsync_q;
      mx        <= frame_edge ? bus.mouse_xpos : mx;
      my        <= frame_edge ? bus.mouse_ypos : my;
      frame_hit <= frame_hit_n;
      lives_q   <= lives_n;
      hit_q     <= hit_n;
      invuln_q  <= invuln_n;
      go_q      <= go_n;
      cnt_q     <= cnt_n;
    end
  end
  // The closing frame also counts an in_box arriving on the edge cycle itself.
  always_comb begin
    state_n     = state;
    lives_n     = lives_q;
    invuln_n    = invuln_q;
    cnt_n       = cnt_q;
    frame_hit_n = frame_hit;
    hit_n       = 1'b0;
    go_n        = go_q;
    case (state)
      IDLE: begin
        lives_n     = '0;
        frame_hit_n = 1'b0;
        if (!stop) begin
          lives_n = 4'(START_LIVES);
          go_n    = 1'b0;
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (frame_edge) begin
          frame_hit_n = 1'b0;
          if ((frame_hit || in_box) && lives_q != '0) begin
            hit_n    = 1'b1;
            lives_n  = lives_q - 4'd1;
            go_n     = lives_q == 4'd1;
            invuln_n = lives_q != 4'd1;
            cnt_n    = lives_q == 4'd1 ? cnt_q : CNT_W'(INVULN_FRAMES - 1);
            state_n  = lives_q == 4'd1 ? GAME_OVER : INVULN;
          end
        end else if (in_box) begin
          frame_hit_n = 1'b1;
        end
      end
      INVULN: begin
        frame_hit_n = 1'b0;
        if (frame_edge) begin
          invuln_n = cnt_q != '0;
          cnt_n    = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
          state_n  = cnt_q == '0 ? ARMED : INVULN;
        end
      end
      default: begin
        go_n        = 1'b1;
        lives_n     = '0;
        frame_hit_n = 1'b0;
      end
    endcase
    if (stop) begin
      state_n     = IDLE;
      lives_n     = '0;
      invuln_n    = 1'b0;
      cnt_n       = '0;
      frame_hit_n = 1'b0;
      hit_n       = 1'b0;
      go_n        = 1'b0;
    end
  end
  assign bus.hit       = hit_q;
  assign bus.lives     = lives_q;
  assign bus.invuln    = invuln_q;
  assign bus.game_over = go_q;
endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector: randomized frame-level check of collision_detector against a lives/immunity reference model
module tb_collision_detector;
  localparam int CW = 16;
  localparam int CH = 16;
  localparam int SL = 3;
  localparam int IF = 60;
  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;
  collision_detector_if bus();
  collision_detector #(
    .CURSOR_W(CW),
    .CURSOR_H(CH),
    .START_LIVES(SL),
    .INVULN_FRAMES(IF)
  ) dut (
    .pclk (pclk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  int total = 0;
  int bad = 0;
  int hit_cnt = 0;
  int long_cnt = 0;
  bit hit_prev = 1'b0;
  int m_on = 0;
  int m_lives = 0;
  int m_inv = 0;
  int m_go = 0;
  bit m_fhit = 1'b0;
  int m_mx = 0;
  int m_my = 0;
  int qx[$];
  int qy[$];
  always @(negedge pclk) begin
    if (bus.hit) begin
      hit_cnt++;
      if (hit_prev) long_cnt++;
    end
    hit_prev = bus.hit;
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int clip(input int v);
    return v < 0 ? 0 : (v > 4095 ? 4095 : v);
  endfunction
  function automatic bit box_m(input int x, input int y, input int mx, input int my);
    return (x != 0 || y != 0) && x >= mx && x < mx + CW && y >= my && y < my + CH;
  endfunction
  task automatic tick();
    @(negedge pclk);
  endtask
  task automatic px(input int x, input int y);
    qx.push_back(x);
    qy.push_back(y);
  endtask
  task automatic check_outs(input string tag);
    chk({tag, ".lives"}, int'(bus.lives), m_lives);
    chk({tag, ".invuln"}, int'(bus.invuln), int'(m_inv > 0));
    chk({tag, ".game_over"}, int'(bus.game_over), m_go);
  endtask
  task automatic run_frame(input int mx, input int my, input bit wiggle);
    int h0;
    int exp_hit;
    int x;
    int y;
    exp_hit = 0;
    if (m_on != 0 && m_go == 0) begin
      if (m_inv > 0) m_inv--;
      else if (m_fhit && m_lives > 0) begin
        exp_hit = 1;
        m_lives--;
        if (m_lives == 0) m_go = 1;
        else m_inv = IF;
      end
    end
    m_fhit = 1'b0;
    h0 = hit_cnt;
    bus.mouse_xpos = 12'(mx);
    bus.mouse_ypos = 12'(my);
    bus.vsync_in = 1'b1;
    repeat (4) tick();
    bus.vsync_in = 1'b0;
    chk("frame.hit_pulses", hit_cnt - h0, exp_hit);
    check_outs("frame");
    m_mx = mx;
    m_my = my;
    while (qx.size() > 0) begin
      x = qx.pop_front();
      y = qy.pop_front();
      bus.obstacle_x = 12'(x);
      bus.obstacle_y = 12'(y);
      if (wiggle) begin
        bus.mouse_xpos = 12'($urandom_range(0, 4095));
        bus.mouse_ypos = 12'($urandom_range(0, 4095));
      end
      if (box_m(x, y, m_mx, m_my)) m_fhit = 1'b1;
      tick();
    end
    bus.obstacle_x = '0;
    bus.obstacle_y = '0;
    repeat (4) tick();
  endtask
  task automatic start_game();
    bus.game_on = 1'b1;
    bus.menu_on = 1'b0;
    tick();
    m_on = 1;
    m_lives = SL;
    m_inv = 0;
    m_go = 0;
    m_fhit = 1'b0;
    check_outs("start");
  endtask
  task automatic stop_game(input bit use_menu);
    if (use_menu) bus.menu_on = 1'b1;
    else bus.game_on = 1'b0;
    tick();
    m_on = 0;
    m_lives = 0;
    m_inv = 0;
    m_go = 0;
    m_fhit = 1'b0;
    check_outs("stop");
  endtask
  task automatic rand_pixels(input int mx, input int my, input int n, input int hit_odds);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, hit_odds) == 0)
        px(clip(mx + $urandom_range(0, CW - 1)), clip(my + $urandom_range(0, CH - 1)));
      else
        px(clip(mx - 4 + $urandom_range(0, 27)), clip(my - 4 + $urandom_range(0, 27)));
    end
  endtask
  task automatic reset_mid();
    int h0;
    bus.obstacle_x = 12'(m_mx + 3);
    bus.obstacle_y = 12'(m_my + 3);
    repeat (2) tick();
    bus.obstacle_x = '0;
    bus.obstacle_y = '0;
    repeat (3) tick();
    h0 = hit_cnt;
    rst_n = 1'b0;
    tick();
    chk("rst_mid.hit", int'(bus.hit), 0);
    chk("rst_mid.lives", int'(bus.lives), 0);
    chk("rst_mid.invuln", int'(bus.invuln), 0);
    chk("rst_mid.game_over", int'(bus.game_over), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_mid.pulses", hit_cnt - h0, 0);
    m_on = 1;
    m_lives = SL;
    m_inv = 0;
    m_go = 0;
    m_fhit = 1'b0;
    m_mx = 0;
    m_my = 0;
    check_outs("rst_mid.restart");
  endtask
  initial begin
    int mx;
    int my;
    bus.vsync_in = 1'b0;
    bus.game_on = 1'b0;
    bus.menu_on = 1'b0;
    bus.obstacle_x = '0;
    bus.obstacle_y = '0;
    bus.mouse_xpos = '0;
    bus.mouse_ypos = '0;
    repeat (3) tick();
    chk("rst.hit", int'(bus.hit), 0);
    check_outs("rst");
    rst_n = 1'b1;
    tick();
    check_outs("idle");
    start_game();
    chk("start.no_pulse", hit_cnt, 0);
    px(499, 410); px(516, 410); px(505, 399); px(505, 416);
    run_frame(500, 400, 1'b0);
    px(0, 0); px(0, 0); px(0, 0);
    run_frame(0, 0, 1'b0);
    px(505, 410);
    run_frame(500, 400, 1'b0);
    px(4095, 4095);
    run_frame(4090, 4090, 1'b0);
    for (int f = 0; f < IF - 1; f++) begin
      mx = $urandom_range(0, 4000);
      my = $urandom_range(0, 4000);
      px(mx + 5, my + 5);
      rand_pixels(mx, my, 6, 3);
      run_frame(mx, my, 1'b0);
    end
    px(4095, 4095);
    run_frame(4090, 4090, 1'b0);
    for (int f = 0; f < IF - 1; f++) begin
      mx = $urandom_range(0, 4000);
      my = $urandom_range(0, 4000);
      px(mx + 8, my + 8);
      run_frame(mx, my, 1'b1);
    end
    px(105, 105); px(3005, 3005);
    run_frame(100, 100, 1'b1);
    run_frame(200, 200, 1'b0);
    stop_game(1'b1);
    start_game();
    run_frame(200, 200, 1'b0);
    reset_mid();
    run_frame(300, 300, 1'b0);
    for (int f = 0; f < 120; f++) begin
      mx = $urandom_range(0, 4095);
      my = $urandom_range(0, 4095);
      rand_pixels(mx, my, 10, $urandom_range(0, 1) == 0 ? 3 : 40);
      run_frame(mx, my, $urandom_range(0, 1) == 1);
      if (m_go != 0 || $urandom_range(0, 14) == 0) begin
        stop_game($urandom_range(0, 1) == 1);
        start_game();
      end
    end
    run_frame(0, 0, 1'b0);
    chk("hit_width", long_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
